csr_file: RTL
=============

# csr_file

Machine-mode control/status register file in the EX stage, answering the CSR requests that ID emits (`csr_we_id2ex`, `csr_addr`, funct3). It performs the Zicsr read-modify-write ops, maintains the trap CSRs (mstatus, mtvec, mepc, mcause, mscratch) and the cycle/retire counters, and records trap entry and `mret` from the pipeline's control path. Reads are combinational, writes commit on the next clock edge.

## Interface
- No parameters. All encodings are fixed in the shared defines.
- `clk` in, 1: single clock; everything samples on the rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `csr_valid` in, 1: the EX instruction is a CSR op. This is the registered `csr_we_id2ex`.
- `csr_op` in, 3: funct3 of the CSR instruction (`CSRRW`/`CSRRS`/`CSRRC`/`CSRRWI`/`CSRRSI`/`CSRRCI`).
- `csr_addr` in, 12: CSR address.
- `rs1_idx` in, 5: rs1 field. For the immediate forms it is used as zimm.
- `rs1_data` in, 32: forwarded rs1 value.
- `csr_rdata` out, 32: old value of the addressed CSR. Combinational.
- `csr_illegal` out, 1: the access is illegal. Combinational.
- `instret_inc` in, 1: one instruction retired this cycle.
- `trap_en` in, 1: take a trap this cycle.
- `trap_pc` in, 32: PC of the trapping instruction.
- `trap_cause` in, 32: mcause value for the trap.
- `mret_en` in, 1: an `mret` is retiring.
- `mtvec_o` out, 32: current mtvec. Reset value 0.
- `mepc_o` out, 32: current mepc. Reset value 0.
- `mie_o` out, 1: mstatus.MIE. Reset value 0.

## Operation
- **Source operand:** `rs1_data` for the register forms; zero-extended `rs1_idx` for the immediate forms.
- **Write value:**
  - RW: new = src.
  - RS: new = old | src.
  - RC: new = old & ~src.
- **Write suppression:**
  - RS, RC, RSI and RCI do not write when `rs1_idx` == 0.
  - RW and RWI always write.
- **Implemented CSRs:**
  - mstatus 0x300: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11; all other bits read 0.
  - misa 0x301: reads 0x40000100; writes are ignored and legal.
  - mtvec 0x305: bits [1:0] are forced to 0.
  - mscratch 0x340: plain 32-bit register.
  - mepc 0x341: bits [1:0] are forced to 0.
  - mcause 0x342: plain 32-bit register.
  - mhartid 0xF14: reads 0.
  - Counters are listed under Configuration.
- **`csr_illegal` = `csr_valid` and (address not implemented, or an effective write to `csr_addr[11:10]`==2'b11).**
  - An illegal access performs no write.
  - `csr_rdata` returns 0 when the address is not implemented.
- **Trap entry (`trap_en`), all at the next edge:**
  - mepc ← `trap_pc`, with [1:0] cleared.
  - mcause ← `trap_cause`.
  - MPIE ← MIE.
  - MIE ← 0.
- **`mret_en`:** MIE ← MPIE and MPIE ← 1.
- **Same-cycle priority:** `trap_en` > `mret_en` > CSR write.
  - A CSR write that coincides with `trap_en` or `mret_en` is dropped entirely.

## Timing
- **Read:** zero latency; `csr_rdata` reflects the pre-edge value.
- **Back-to-back:** a write in cycle N is visible to a read in cycle N+1.
- **Reset values:** every CSR resets to 0 except misa (constant) and MPP (constant 2'b11). All outputs are 0 during and after reset.
- **Reset mid-operation:** `rst` overrides every write, trap and increment in that cycle.
- **Counters:** 64-bit and wrap to 0 from all-ones.
  - A CSR write to one half in the same cycle as an increment: the written half takes the written value, the other half holds (no increment and no carry that cycle).

## Configuration
- Macro: `CSR_COUNTERS_EN`.
- **Defined:**
  - mcycle increments every cycle.
  - minstret increments on `instret_inc`.
  - Read/write addresses: mcycle 0xB00/0xB80 and minstret 0xB02/0xB82.
  - Read-only shadows: cycle 0xC00/0xC80 and instret 0xC02/0xC82.
- **Undefined:** the counter registers are absent and all eight addresses are unimplemented, so they are illegal and read 0.

## Structure
- CSR address constants, the funct3 encodings and the misa value belong in the shared defines file, next to the existing `CSR`/`CSRRW`… macros.
- One sub-module, `csr_counter64`, instantiated twice (mcycle, minstret). It has:
  - an increment enable;
  - per-half write enables;
  - a 32-bit write data input;
  - a 64-bit value output.

## Test plan
- **CSRRW to mscratch then CSRRS read:** CSRRW mscratch with `rs1_data`=0xDEADBEEF returns old 0. The next cycle, CSRRS with `rs1_idx`=0 returns 0xDEADBEEF and leaves mscratch unchanged.
- **CSRRCI on mstatus:** with mstatus=0x1888, CSRRCI zimm=8 gives `csr_rdata`=0x1888; mstatus becomes 0x1880 and `mie_o`=0.
- **Trap, then mret:** with MIE=1, `trap_en`, `trap_pc`=0x103 and `trap_cause`=11 give mepc=0x100, mcause=11, MIE=0, MPIE=1. A later `mret_en` gives MIE=1.
- **Trap with simultaneous CSRRW:** CSRRW mepc=0x500 in the same cycle as `trap_en` (`trap_pc`=0x200) leaves mepc=0x200.
- **Illegal accesses:** CSRRW to 0xC00 or to 0x7C0 asserts `csr_illegal` and changes no state. CSRRS 0xC00 with `rs1_idx`=0 is legal.
- **Counter wrap (`CSR_COUNTERS_EN`):** write mcycle 0xFFFFFFFF and mcycleh 0xFFFFFFFF; two cycles later mcycle reads 0x00000000 and mcycleh reads 0.

Source files
------------

// File: rtl/csr_file_pkg.sv
// Shared CSR encodings for csr_file: funct3 op codes, CSR addresses, the misa constant
// and the Zicsr read-modify-write helper.
package csr_file_pkg;

  // funct3 encodings of the Zicsr instructions
  localparam logic [2:0] Csrrw  = 3'b001;
  localparam logic [2:0] Csrrs  = 3'b010;
  localparam logic [2:0] Csrrc  = 3'b011;
  localparam logic [2:0] Csrrwi = 3'b101;
  localparam logic [2:0] Csrrsi = 3'b110;
  localparam logic [2:0] Csrrci = 3'b111;

  // Machine-mode CSR addresses
  localparam logic [11:0] CsrMstatus  = 12'h300;
  localparam logic [11:0] CsrMisa     = 12'h301;
  localparam logic [11:0] CsrMtvec    = 12'h305;
  localparam logic [11:0] CsrMscratch = 12'h340;
  localparam logic [11:0] CsrMepc     = 12'h341;
  localparam logic [11:0] CsrMcause   = 12'h342;
  localparam logic [11:0] CsrMhartid  = 12'hF14;

  // Counter addresses (only implemented with CSR_COUNTERS_EN)
  localparam logic [11:0] CsrMcycle    = 12'hB00;
  localparam logic [11:0] CsrMcycleh   = 12'hB80;
  localparam logic [11:0] CsrMinstret  = 12'hB02;
  localparam logic [11:0] CsrMinstreth = 12'hB82;
  localparam logic [11:0] CsrCycle     = 12'hC00;
  localparam logic [11:0] CsrCycleh    = 12'hC80;
  localparam logic [11:0] CsrInstret   = 12'hC02;
  localparam logic [11:0] CsrInstreth  = 12'hC82;

  // RV32I, machine mode only
  localparam logic [31:0] MisaValue = 32'h4000_0100;

  // New CSR value for an op; op[1:0] selects RW/RS/RC for both register and immediate forms
  function automatic logic [31:0] csr_wval(logic [1:0] op, logic [31:0] old_val,
                                           logic [31:0] src);
    logic [31:0] res;
    unique case (op)
      2'b01:   res = src;
      2'b10:   res = old_val | src;
      2'b11:   res = old_val & ~src;
      default: res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter with per-half write. A half write wins over the increment for that cycle:
// the written half takes the data, the other half holds, and no carry propagates.
module csr_counter64 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  input  logic        we_lo_i,
  input  logic        we_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] value_o
);

  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;

  // Next-state: half write, else increment with wrap
  always_comb begin
    lo_d = lo_q;
    hi_d = hi_q;
    if (we_lo_i) begin
      lo_d = wdata_i;
    end else if (we_hi_i) begin
      hi_d = wdata_i;
    end else if (inc_i) begin
      {hi_d, lo_d} = {hi_q, lo_q} + 64'd1;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

  assign value_o = {hi_q, lo_q};

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file in EX: Zicsr read-modify-write, trap entry/mret bookkeeping and,
// when CSR_COUNTERS_EN is defined, the mcycle/minstret counters with read-only shadows.
module csr_file
  import csr_file_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_valid,
  input  logic [2:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [4:0]  rs1_idx,
  input  logic [31:0] rs1_data,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        instret_inc,
  input  logic        trap_en,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic        mret_en,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        mie_o
);

  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;

  logic [31:0] src;
  logic [31:0] old_val;
  logic [31:0] wval;
  logic        implemented;
  logic        is_write;
  logic        wr_fire;

  // Low PC bits are always discarded on trap entry
  logic [1:0] unused_trap_pc;
  assign unused_trap_pc = trap_pc[1:0];

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_val;
  logic [63:0] minstret_val;

  csr_counter64 u_mcycle (
    .clk_i   (clk),
    .rst_i   (rst),
    .inc_i   (1'b1),
    .we_lo_i (wr_fire && (csr_addr == CsrMcycle)),
    .we_hi_i (wr_fire && (csr_addr == CsrMcycleh)),
    .wdata_i (wval),
    .value_o (mcycle_val)
  );

  csr_counter64 u_minstret (
    .clk_i   (clk),
    .rst_i   (rst),
    .inc_i   (instret_inc),
    .we_lo_i (wr_fire && (csr_addr == CsrMinstret)),
    .we_hi_i (wr_fire && (csr_addr == CsrMinstreth)),
    .wdata_i (wval),
    .value_o (minstret_val)
  );
`else
  logic unused_instret_inc;
  assign unused_instret_inc = instret_inc;
`endif

  // Read decode: raw value of the addressed CSR and whether it exists
  always_comb begin
    implemented = 1'b1;
    old_val     = '0;
    case (csr_addr)
      CsrMstatus:  old_val = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
      CsrMisa:     old_val = MisaValue;
      CsrMtvec:    old_val = mtvec_q;
      CsrMscratch: old_val = mscratch_q;
      CsrMepc:     old_val = mepc_q;
      CsrMcause:   old_val = mcause_q;
      CsrMhartid:  old_val = '0;
`ifdef CSR_COUNTERS_EN
      CsrMcycle,    CsrCycle:    old_val = mcycle_val[31:0];
      CsrMcycleh,   CsrCycleh:   old_val = mcycle_val[63:32];
      CsrMinstret,  CsrInstret:  old_val = minstret_val[31:0];
      CsrMinstreth, CsrInstreth: old_val = minstret_val[63:32];
`endif
      default: implemented = 1'b0;
    endcase
  end

  // Operand, write value and legality; set/clear with a zero rs1 field is a pure read
  always_comb begin
    src         = csr_op[2] ? {27'b0, rs1_idx} : rs1_data;
    wval        = csr_wval(csr_op[1:0], old_val, src);
    is_write    = (csr_op[1:0] == 2'b01) || ((csr_op[1] == 1'b1) && (rs1_idx != 5'd0));
    csr_illegal = csr_valid && (!implemented || (is_write && (csr_addr[11:10] == 2'b11)));
    wr_fire     = csr_valid && is_write && !csr_illegal && !trap_en && !mret_en;
    // Gated by csr_valid so the bus is quiet when no CSR op is in EX
    csr_rdata   = csr_valid ? old_val : 32'h0;
  end

  // Next-state: trap entry beats mret, which beats a CSR write
  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    if (trap_en) begin
      mepc_d   = {trap_pc[31:2], 2'b00};
      mcause_d = trap_cause;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret_en) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (wr_fire) begin
      case (csr_addr)
        CsrMstatus: begin
          mie_d  = wval[3];
          mpie_d = wval[7];
        end
        CsrMtvec:    mtvec_d    = {wval[31:2], 2'b00};
        CsrMscratch: mscratch_d = wval;
        CsrMepc:     mepc_d     = {wval[31:2], 2'b00};
        CsrMcause:   mcause_d   = wval;
        default: ;
      endcase
    end
  end

  // CSR state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;
  assign mie_o   = mie_q;

endmodule
